// File: rtl/uart_rx_stub.sv
// -----------------------------------------------------------------------------
// uart_rx_stub
// Receive-side counterpart of the simulation UART write port. Bytes arriving
// from a host-side source are buffered in a circular FIFO and served to CPU
// loads through a DATA register (word offset 0) and a STATUS register (word
// offset 1). Loads are non-idempotent, so every accepted load raises a
// difftest skip pulse together with its response.
//
// Ports
//   clock          single clock, all state on posedge
//   reset_n        asynchronous active-low reset
//   host_valid_i   host presents a byte this cycle (no backpressure)
//   host_data_i    byte from host
//   rd_en_i        CPU load request, one cycle per request
//   rd_addr_i      0 = DATA, 1 = STATUS
//   rd_valid_o     load response valid, one cycle after the request
//   rd_data_o      load response data, held until the next response
//   skip_o         difftest skip pulse, aligned with rd_valid_o
//   rx_nonempty_o  FIFO holds at least one byte (registered level)
//
// STATUS layout: bit0 = nonempty, bit1 = full, bit2 = overflow (sticky,
// cleared by a STATUS read), bits[15:8] = occupancy count.
// -----------------------------------------------------------------------------
module uart_rx_stub #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        host_valid_i,
    input  logic [7:0]  host_data_i,
    input  logic        rd_en_i,
    input  logic        rd_addr_i,
    output logic        rd_valid_o,
    output logic [31:0] rd_data_o,
    output logic        skip_o,
    output logic        rx_nonempty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [31:0]      DATA_NONE = 32'hFFFF_FFFF;

    // FIFO storage and bookkeeping
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ovf_q,    ovf_d;

    // Load response and level outputs
    logic             rd_valid_q, rd_valid_d;
    logic [31:0]      rd_data_q,  rd_data_d;
    logic             skip_q,     skip_d;
    logic             nonempty_q, nonempty_d;

    // Combinational decode of the current cycle
    logic             full_c;
    logic             empty_c;
    logic             data_rd_c;
    logic             stat_rd_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;
    logic [7:0]       head_c;
    logic [31:0]      status_c;

    // Occupancy flags, request decode and push/pop/drop qualification
    always_comb begin
        full_c    = (count_q == CNT_FULL);
        empty_c   = (count_q == '0);
        data_rd_c = rd_en_i & ~rd_addr_i;
        stat_rd_c = rd_en_i &  rd_addr_i;
        pop_c     = data_rd_c & ~empty_c;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push_c    = host_valid_i & (~full_c | pop_c);
        drop_c    = host_valid_i & full_c & ~pop_c;
        head_c    = mem_q[rd_ptr_q];
        status_c  = {16'h0000, 8'(count_q), 5'b00000, ovf_q, full_c, ~empty_c};
    end

    // Next-state for pointers, count, overflow flag and response registers
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        rd_valid_d = 1'b0;
        skip_d     = 1'b0;
        rd_data_d  = rd_data_q;
        nonempty_d = nonempty_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a STATUS read keeps the flag set.
        if (drop_c) begin
            ovf_d = 1'b1;
        end else if (stat_rd_c) begin
            ovf_d = 1'b0;
        end

        if (rd_en_i) begin
            rd_valid_d = 1'b1;
            skip_d     = 1'b1;
            if (rd_addr_i) begin
                rd_data_d = status_c;
            end else if (empty_c) begin
                rd_data_d = DATA_NONE;
            end else begin
                rd_data_d = {24'h00_0000, head_c};
            end
        end

        nonempty_d = (count_d != '0);
    end

    // FIFO storage write port
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= host_data_i;
        end
    end

    // Control and response state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            skip_q     <= 1'b0;
            nonempty_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            skip_q     <= skip_d;
            nonempty_q <= nonempty_d;
        end
    end

    assign rd_valid_o    = rd_valid_q;
    assign rd_data_o     = rd_data_q;
    assign skip_o        = skip_q;
    assign rx_nonempty_o = nonempty_q;

endmodule
